// File: rtl/draw_sprite.sv
// draw_sprite: overlays a ROM-backed sprite on the VGA stream through a fixed 3-clock pipeline
module draw_sprite #(
  parameter int WIDTH = 32,
  parameter int HEIGHT = 32,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        visible,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  logic [11:0] xpos_q, ypos_q, rom_addr_q, addr_d, rgb_q1, rgb_q2, rgb_q3, rgb_d;
  logic        vis_q, vblnk_prev_q, inbox, inbox_q1, inbox_q2;
  logic [12:0] hc, vc, xp, yp;
  logic [5:0]  dx, dy;
  logic [25:0] tim_in, tim_q1, tim_q2, tim_q3;
  assign tim_in = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
  // in-box test on the incoming pixel, ROM address, and final compositing mux
  always_comb begin
    hc = {2'b00, hcount_in};
    vc = {2'b00, vcount_in};
    xp = {1'b0, xpos_q};
    yp = {1'b0, ypos_q};
    dx = hcount_in[5:0] - xpos_q[5:0];
    dy = vcount_in[5:0] - ypos_q[5:0];
    inbox = vis_q && hc >= xp && hc < xp + 13'(WIDTH) && vc >= yp && vc < yp + 13'(HEIGHT)
            && !hblnk_in && !vblnk_in;
    addr_d = inbox ? {dy, dx} : 12'h000;
    rgb_d = (tim_q2[13] || tim_q2[0]) ? 12'h000
          : (inbox_q2 && rom_data != KEY_COLOR) ? rom_data : rgb_q2;
  end
  // position is sampled only on the rising edge of vertical blank so a frame never tears
  always_ff @(posedge pclk) begin
    if (rst) begin
      xpos_q <= '0;
      ypos_q <= '0;
      vis_q <= 1'b0;
      vblnk_prev_q <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (vblnk_in && !vblnk_prev_q) begin
        xpos_q <= xpos;
        ypos_q <= ypos;
        vis_q <= visible;
      end
    end
  end
  // three-stage pipeline: address/timing, ROM wait, composite
  always_ff @(posedge pclk) begin
    if (rst) begin
      rom_addr_q <= '0;
      inbox_q1 <= 1'b0;
      inbox_q2 <= 1'b0;
      tim_q1 <= '0;
      tim_q2 <= '0;
      tim_q3 <= '0;
      rgb_q1 <= '0;
      rgb_q2 <= '0;
      rgb_q3 <= '0;
    end else begin
      rom_addr_q <= addr_d;
      inbox_q1 <= inbox;
      inbox_q2 <= inbox_q1;
      tim_q1 <= tim_in;
      tim_q2 <= tim_q1;
      tim_q3 <= tim_q2;
      rgb_q1 <= rgb_in;
      rgb_q2 <= rgb_q1;
      rgb_q3 <= rgb_d;
    end
  end
  assign rom_addr = rom_addr_q;
  assign {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} = tim_q3;
  assign rgb_out = rgb_q3;
endmodule

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: directed scoreboard bench for draw_sprite with a synchronous ROM model
module tb_draw_sprite;
  logic        pclk = 1'b0, rst = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0, hcount_out, vcount_out;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_in = '0, xpos = '0, ypos = '0, rom_addr, rom_data, rgb_out;
  logic        visible = 1'b0;
  bit          mode = 1'b0, bg_const = 1'b1;
  typedef struct packed {logic [25:0] tim; logic [11:0] rgb;} exp_t;
  exp_t q[$];
  int mx = 0, my = 0, passed = 0, total = 0, abc = 0;
  bit mvis = 1'b0, mprev = 1'b0;

  draw_sprite dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .visible(visible),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  function automatic logic [11:0] rom_f(logic [11:0] a, bit m);
    return (m && a[5:0] < 6'd16) ? 12'hF0F : 12'hABC;
  endfunction

  always @(posedge pclk) rom_data <= rom_f(rom_addr, mode);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    exp_t e;
    logic [11:0] ea;
    bit ib;
    int dx, dy;
    ib = mvis && hcount_in >= mx && hcount_in < mx + 32 && vcount_in >= my && vcount_in < my + 32
         && !hblnk_in && !vblnk_in;
    dx = hcount_in - mx;
    dy = vcount_in - my;
    ea = (ib && !rst) ? {6'(dy), 6'(dx)} : 12'h000;
    if (rst) begin
      q.delete();
      e = '0;
      repeat (3) q.push_back(e);
      mx = 0; my = 0; mvis = 1'b0; mprev = 1'b0;
    end else begin
      e.tim = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
      e.rgb = (hblnk_in || vblnk_in) ? 12'h000
            : (ib && rom_f(ea, mode) != 12'hF0F) ? rom_f(ea, mode) : rgb_in;
      q.push_back(e);
      if (vblnk_in && !mprev) begin
        mx = int'(xpos); my = int'(ypos); mvis = visible;
      end
      mprev = vblnk_in;
    end
    @(posedge pclk);
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(ea));
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("timing", 32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}), 32'(e.tim));
      chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
      if (rgb_out == 12'hABC) abc++;
    end
  endtask

  task automatic drive(int h, int v);
    hcount_in = 11'(h);
    hblnk_in = h >= 800;
    hsync_in = h >= 840 && h < 968;
    vcount_in = 11'(v);
    vblnk_in = v >= 600;
    vsync_in = v >= 601 && v < 605;
    rgb_in = bg_const ? 12'h123 : {4'h1, 4'(h) ^ 4'(v), 4'h5};
    step();
  endtask

  task automatic line(int v, int h0, int h1);
    for (int h = h0; h <= h1; h++) drive(h, v);
  endtask

  task automatic flush();
    drive(900, 10);
    drive(900, 10);
  endtask

  task automatic latch();
    drive(0, 599);
    drive(0, 600);
    drive(0, 601);
    drive(0, 0);
  endtask

  task automatic count_line(string tag, int v, int want);
    flush();
    abc = 0;
    line(v, 0, 1055);
    flush();
    chk(tag, 32'(abc), 32'(want));
  endtask

  task automatic rst_pulse(int h, int v);
    rst = 1'b1;
    drive(h, v);
    rst = 1'b0;
  endtask

  initial begin
    rst_pulse(0, 0);
    // pass-through with constant background, crossing into both blanks
    line(10, 790, 810);
    line(599, 795, 805);
    line(600, 0, 5);
    // placement at (100,50)
    bg_const = 1'b0;
    xpos = 12'd100; ypos = 12'd50; visible = 1'b1;
    latch();
    line(50, 95, 135);
    line(81, 95, 135);
    line(82, 95, 135);
    line(49, 95, 135);
    drive(105, 60);
    chk("rom_addr_105_60", 32'(rom_addr), 32'h285);
    count_line("abc_place", 60, 32);
    // transparency: left half of sprite is key colour
    mode = 1'b1;
    count_line("abc_transp", 60, 16);
    line(60, 110, 120);
    mode = 1'b0;
    flush();
    // clipping at bottom-right corner
    xpos = 12'd790; ypos = 12'd590;
    latch();
    line(590, 785, 805);
    line(599, 785, 805);
    line(600, 785, 805);
    count_line("abc_clip", 595, 10);
    // far-right position must not wrap to column 0
    xpos = 12'd4090; ypos = 12'd50;
    latch();
    count_line("abc_nowrap", 50, 0);
    // position change mid-frame waits for next vertical blank
    xpos = 12'd100; ypos = 12'd290;
    latch();
    line(300, 95, 140);
    xpos = 12'd200;
    line(301, 95, 240);
    count_line("abc_old_pos", 302, 32);
    latch();
    line(300, 95, 240);
    count_line("abc_new_pos", 301, 32);
    // reset mid-line clears outputs and stored position
    xpos = 12'd10; ypos = 12'd300;
    rst_pulse(400, 300);
    line(300, 401, 420);
    count_line("abc_after_rst", 300, 0);
    latch();
    line(300, 5, 45);
    count_line("abc_relatch", 310, 32);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
